// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : byte/half/word load-store front end for a word-only memory
// Revision 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_MERGE  = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merge_buf_q, merge_buf_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wd_q, mem_wd_d;

   logic        accept;
   logic        illegal;
   logic [1:0]  eff_size;
   logic [4:0]  shamt;
   logic [31:0] lane_rd;
   logic [31:0] load_ext;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;
   logic [31:0] merged;
   logic        mem_we_raw;

   assign accept   = req_valid && (state_q == ST_IDLE);
   assign illegal  = ALIGN_CHECK && ((req_size == 2'd3) ||
                                     ((req_size == 2'd1) && req_addr[0]) ||
                                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)));
   // Without alignment checking, the illegal size degrades to a word access.
   assign eff_size = (req_size == 2'd3) ? 2'd2 : req_size;

   // Halfwords only look at offset bit 1, so a stray bit 0 is ignored.
   assign shamt    = (size_q == 2'd0) ? {off_q, 3'b000} : {off_q[1], 4'b0000};
   assign lane_rd  = mem_rd >> shamt;

   always_comb begin
      load_ext = mem_rd;
      case (size_q)
         2'd0:    load_ext = uns_q ? {24'd0, lane_rd[7:0]}
                                   : {{24{lane_rd[7]}}, lane_rd[7:0]};
         2'd1:    load_ext = uns_q ? {16'd0, lane_rd[15:0]}
                                   : {{16{lane_rd[15]}}, lane_rd[15:0]};
         default: load_ext = mem_rd;
      endcase
   end

   assign lane_mask = ((size_q == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
   assign lane_data = ((size_q == 2'd0) ? {24'd0, wdata_q[7:0]}
                                        : {16'd0, wdata_q[15:0]}) << shamt;
   assign merged    = (merge_buf_q & ~lane_mask) | lane_data;

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      merge_buf_d = merge_buf_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      mem_addr_d  = mem_addr_q;
      mem_we_raw  = 1'b0;
      mem_wd      = mem_wd_q;
      req_ready   = (state_q == ST_IDLE);
      rsp_valid   = (state_q == ST_RESP);

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               we_d    = req_we;
               size_d  = eff_size;
               uns_d   = req_unsigned;
               off_d   = req_addr[1:0];
               wdata_d = req_wdata;
               rdata_d = 32'd0;
               err_d   = illegal;
               if (illegal) begin
                  state_d = ST_RESP;
               end else begin
                  state_d    = ST_ACCESS;
                  mem_addr_d = {req_addr[31:2], 2'b00};
               end
            end
         end
         ST_ACCESS: begin
            if (!we_q) begin
               rdata_d = load_ext;
               state_d = ST_RESP;
            end else if (size_q == 2'd2) begin
               mem_we_raw = 1'b1;
               mem_wd     = wdata_q;
               state_d    = ST_RESP;
            end else begin
               merge_buf_d = mem_rd;
               state_d     = ST_MERGE;
            end
         end
         ST_MERGE: begin
            mem_we_raw = 1'b1;
            mem_wd     = merged;
            state_d    = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A write pending during a reset cycle must never reach the memory.
   assign mem_we    = mem_we_raw && !reset;
   assign mem_wd_d  = mem_wd;
   assign mem_addr  = mem_addr_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'd0;
         uns_q       <= 1'b0;
         off_q       <= 2'd0;
         wdata_q     <= 32'd0;
         merge_buf_q <= 32'd0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wd_q    <= 32'd0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         merge_buf_q <= merge_buf_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         mem_addr_q  <= mem_addr_d;
         mem_wd_q    <= mem_wd_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit : directed + random bench against a transaction-level model
// Revision 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   always #5 clk = ~clk;

   mem_access_unit #(.ALIGN_CHECK(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wd       (mem_wd),
      .mem_rd       (mem_rd)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic        load_mem;

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
      end else if (mem_we) begin
         mem[mem_addr[9:2]] <= mem_wd;
      end
   end
   assign mem_rd = mem[mem_addr[9:2]];

   logic        mon_en     = 1'b0;
   logic        txn_active = 1'b0;
   logic [31:0] exp_rdata  = 32'd0;
   logic        exp_err    = 1'b0;
   logic        exp_wr_ok  = 1'b0;
   logic [31:0] exp_waddr  = 32'd0;
   logic [31:0] exp_wword  = 32'd0;
   int          we_cnt     = 0;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: what a byte-addressed memory would return.
   task automatic model_txn(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int lat,
                            output logic [31:0] new_word);
      logic [31:0] word;
      logic [7:0]  b;
      logic [15:0] h;
      int          bo;
      int          ho;
      err      = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
      rdata    = 32'd0;
      word     = ref_mem[addr[9:2]];
      new_word = word;
      bo       = int'(addr[1:0]);
      ho       = int'(addr[1]);
      if (err) begin
         lat = 1;
      end else if (!we) begin
         lat = 2;
         b   = word[8*bo +: 8];
         h   = word[16*ho +: 16];
         if (size == 2'd0)      rdata = uns ? {24'd0, b} : {{24{b[7]}}, b};
         else if (size == 2'd1) rdata = uns ? {16'd0, h} : {{16{h[15]}}, h};
         else                   rdata = word;
      end else begin
         if (size == 2'd2) begin
            lat      = 2;
            new_word = wdata;
         end else begin
            lat = 3;
            if (size == 2'd0) new_word[8*bo +: 8]   = wdata[7:0];
            else              new_word[16*ho +: 16] = wdata[15:0];
         end
         ref_mem[addr[9:2]] = new_word;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk(req_ready === !txn_active, "req_ready", {31'd0, req_ready}, {31'd0, !txn_active});
         chk(mem_addr[1:0] == 2'b00, "mem_addr_align", mem_addr, {mem_addr[31:2], 2'b00});
         if (!txn_active)
            chk(rsp_valid === 1'b0 && mem_we === 1'b0, "idle_quiet", {30'd0, rsp_valid, mem_we}, 32'd0);
         if (mem_we === 1'b1) begin
            we_cnt++;
            chk(exp_wr_ok && mem_addr == exp_waddr, "mem_waddr", mem_addr, exp_waddr);
            chk(mem_wd == exp_wword, "mem_wd", mem_wd, exp_wword);
         end
         if (rsp_valid === 1'b1) begin
            chk(rsp_rdata == exp_rdata, "rsp_rdata", rsp_rdata, exp_rdata);
            chk(rsp_err == exp_err, "rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
         end
      end
   end

   // Called #1 after a posedge; returns #1 after the handshake posedge.
   task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int bp,
                         input bit lit, input logic [31:0] lit_rdata);
      logic        rdy;
      logic        got;
      logic        e_err;
      logic [31:0] e_rdata;
      logic [31:0] e_word;
      int          e_lat;
      int          n;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      got          = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk);
         if (rdy) got = 1'b1;
      end
      chk(got, "accept_timeout", {31'd0, got}, 32'd1);
      model_txn(we, size, uns, addr, wdata, e_rdata, e_err, e_lat, e_word);
      exp_rdata  = e_rdata;
      exp_err    = e_err;
      exp_wr_ok  = we && !e_err;
      exp_waddr  = {addr[31:2], 2'b00};
      exp_wword  = e_word;
      we_cnt     = 0;
      txn_active = 1'b1;
      #1;
      req_valid    = 1'($urandom % 2);
      req_we       = 1'($urandom % 2);
      req_size     = 2'($urandom % 4);
      req_unsigned = 1'($urandom % 2);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rsp_valid !== 1'b1 && n < 10);
      chk(n == e_lat, "latency", n, e_lat);
      if (lit) chk(rsp_rdata == lit_rdata, "lit_rdata", rsp_rdata, lit_rdata);
      for (int i = 0; i < bp; i++) @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready  = 1'b0;
      req_valid  = 1'b0;
      txn_active = 1'b0;
      chk(we_cnt == (exp_wr_ok ? 1 : 0), "we_pulses", we_cnt, exp_wr_ok ? 1 : 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk(req_ready == 1'b1 && rsp_valid == 1'b0 && rsp_err == 1'b0 && mem_we == 1'b0,
          {tag, "_ctrl"}, {28'd0, req_ready, rsp_valid, rsp_err, mem_we}, 32'h8);
      chk(rsp_rdata == 32'd0, {tag, "_rdata"}, rsp_rdata, 32'd0);
      chk(mem_addr == 32'd0, {tag, "_mem_addr"}, mem_addr, 32'd0);
      chk(mem_wd == 32'd0, {tag, "_mem_wd"}, mem_wd, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rw;
      logic [1:0]  rs;
      for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
      ref_mem[16]  = 32'h8899AABB;
      reset        = 1'b1;
      load_mem     = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      rsp_ready    = 1'b0;
      @(posedge clk);
      #1 load_mem = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      reset  = 1'b0;
      mon_en = 1'b1;

      do_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 0, 1'b1, 32'h8899AABB);
      do_txn(1'b0, 2'd0, 1'b0, 32'h41, 32'd0, 0, 1'b1, 32'hFFFFFFAA);
      do_txn(1'b0, 2'd0, 1'b1, 32'h41, 32'd0, 1, 1'b1, 32'h000000AA);
      do_txn(1'b0, 2'd1, 1'b0, 32'h42, 32'd0, 0, 1'b1, 32'hFFFF8899);
      do_txn(1'b0, 2'd1, 1'b1, 32'h40, 32'd0, 0, 1'b1, 32'h0000AABB);
      do_txn(1'b1, 2'd0, 1'b0, 32'h43, 32'h12345677, 0, 1'b1, 32'd0);
      chk(mem[16] == 32'h7799AABB, "lit_word_sb", mem[16], 32'h7799AABB);
      do_txn(1'b1, 2'd1, 1'b0, 32'h40, 32'h0000CAFE, 0, 1'b1, 32'd0);
      chk(mem[16] == 32'h7799CAFE, "lit_word_sh", mem[16], 32'h7799CAFE);
      do_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 0, 1'b1, 32'h7799CAFE);
      do_txn(1'b1, 2'd1, 1'b0, 32'h41, 32'h1111, 0, 1'b1, 32'd0);
      do_txn(1'b0, 2'd2, 1'b0, 32'h42, 32'd0, 0, 1'b1, 32'd0);
      do_txn(1'b0, 2'd3, 1'b0, 32'h40, 32'd0, 0, 1'b1, 32'd0);
      do_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 5, 1'b1, 32'h7799CAFE);

      // Reset arriving while the sub-word merge write is pending.
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr  = 32'h40; req_wdata = 32'h000000EE;
      @(negedge clk);
      chk(req_ready == 1'b1, "rst_pre_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      exp_wr_ok  = 1'b0;
      exp_rdata  = 32'd0;
      exp_err    = 1'b0;
      txn_active = 1'b1;
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk(mem_we == 1'b0, "rst_no_write", {31'd0, mem_we}, 32'd0);
      @(posedge clk);
      #1;
      txn_active = 1'b0;
      chk_reset_outputs("midrst");
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk(mem[16] == 32'h7799CAFE, "rst_word_kept", mem[16], 32'h7799CAFE);

      for (int k = 0; k < 300; k++) begin
         ra = $urandom_range(0, 1023);
         rw = $urandom;
         rs = 2'($urandom % 4);
         do_txn(1'($urandom % 2), rs, 1'($urandom % 2), ra, rw, int'($urandom % 3), 1'b0, 32'd0);
      end

      for (int i = 0; i < 256; i++) chk(mem[i] == ref_mem[i], "final_mem", mem[i], ref_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
